predictor_gshare_bht: RTL and testbench
=======================================

Name: predictor_gshare_bht

Overview:
Parametrised two-level branch predictor for the fetch stage, successor to the fixed 2-bit-history, 4-bank, 2-bit-counter predictor. It supports the following:
- configurable global history length, table depth and counter width;
- two index modes: bank-concatenate and gshare XOR;
- a speculative global history register (GHR) that shifts at fetch and is repaired from the EX-stage snapshot on a mispredict;
- a table-initialisation sweep FSM, run after reset and on flush.

Parameters:
ENTRY_NUM, 256, number of counters; power of two, >= 16.
IDX_WIDTH, $clog2(ENTRY_NUM), table index width (derived).
GHR_WIDTH, 8, global history length; 1..IDX_WIDTH.
CNT_WIDTH, 2, saturating counter width; 2..4.
INDEX_MODE, 1, 0 = {ghr[GHR_WIDTH-1:0], pc[IDX_WIDTH-GHR_WIDTH+1:2]}; 1 = pc[IDX_WIDTH+1:2] ^ zero-extended ghr.

Ports:
cpu_clk  input  1  core clock.
cpu_rstn  input  1  asynchronous active-low reset.
flush_req  input  1  single-cycle request to re-initialise table and clear GHR.
init_busy  output  1  high while the init sweep runs.
pred_req  input  1  fetch is consuming a prediction for next_pc this cycle.
next_pc  input  ADDR_WIDTH  fetch PC to predict.
pred_taken  output  1  predicted direction (counter MSB).
pred_counter  output  CNT_WIDTH  raw counter value at the read index.
pred_ghr  output  GHR_WIDTH  speculative GHR used for this prediction; pipelined with the branch to EX.
branch_ex  input  1  a conditional branch resolves in EX this cycle.
branch_taken_ex  input  1  resolved direction.
branch_pred_ex  input  1  direction that was predicted for this branch.
branch_pc_ex  input  ADDR_WIDTH  PC of the resolving branch.
branch_ghr_ex  input  GHR_WIDTH  pred_ghr snapshot carried with the branch.
mispredict_ex  output  1  branch_ex && (branch_taken_ex != branch_pred_ex); combinational.

Behaviour:
Storage:
- ENTRY_NUM x CNT_WIDTH counter array with combinational read and write on the cpu_clk rising edge.
- The array has no reset; it is written by the sweep.
- WNT (weakly-not-taken) = 2^(CNT_WIDTH-1)-1. CMAX = 2^CNT_WIDTH-1.

Read index:
- Formed from next_pc and spec_ghr per INDEX_MODE.
- pred_counter = table[ridx]; pred_taken = pred_counter[CNT_WIDTH-1]; pred_ghr = spec_ghr (pre-shift value).

Write index:
- Same function applied to branch_pc_ex and branch_ghr_ex, so the update hits the entry that produced the prediction.

FSM states:
- INIT: writes WNT to table[init_idx] each cycle and increments init_idx. At init_idx == ENTRY_NUM-1 the last write occurs and the next state is IDLE. init_busy = 1.
- IDLE: normal operation. init_busy = 0. flush_req -> INIT with init_idx = 0.

Reset values:
- state = INIT, init_idx = 0, spec_ghr = 0, init_busy = 1.
- pred_taken = 0 and pred_counter = 0 while init_busy is high (outputs are forced).
- The sweep takes ENTRY_NUM cycles; init_busy falls on the first edge after the final write.

During INIT:
- pred_req does not shift the GHR.
- branch_ex updates are dropped.
- mispredict_ex is still reported.
- flush_req restarts the sweep at 0.

Counter update (IDLE, branch_ex):
- taken: counter + 1, saturating at CMAX.
- not taken: counter - 1, saturating at 0.

Speculative GHR (IDLE), priority high to low:
1. flush_req: spec_ghr <= 0.
2. mispredict_ex: spec_ghr <= {branch_ghr_ex[GHR_WIDTH-2:0], branch_taken_ex}; for GHR_WIDTH = 1 it is branch_taken_ex. A same-cycle pred_req shift is discarded because it is wrong-path.
3. pred_req: spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred_taken}.
4. Otherwise spec_ghr holds.

Simultaneous events and boundaries:
- A correctly predicted branch_ex does not touch spec_ghr.
- Same-cycle read and update of the same index: the read returns the pre-update value; the new value is visible next cycle.
- flush_req in the same cycle as branch_ex: the update is dropped, because the sweep overwrites the table anyway.
- Asynchronous reset mid-sweep or mid-update: immediate return to the reset values, and the sweep restarts.

Test Plan:
1. Reset release (defaults) -> init_busy = 1 for exactly 256 cycles, then 0. A pred_req at any PC then gives pred_counter = 2'b01 and pred_taken = 0.
2. IDLE, INDEX_MODE = 1, spec_ghr = 0, PC 0x100 (index 0x40). Three taken branch_ex updates with branch_ghr_ex = 0 -> counter goes 01, 10, 11, 11 (saturates). A read of 0x100 with ghr 0 gives pred_taken = 1.
3. pred_req x3 with predictions 1, 0, 1 from spec_ghr = 0 -> pred_ghr sequence 0x00, 0x01, 0x02; spec_ghr = 0x05 afterwards.
4. mispredict_ex with branch_ghr_ex = 0x81, branch_taken_ex = 1, plus a pred_req in the same cycle -> spec_ghr = 0x03 and the pred_req shift is ignored. A correct prediction (branch_pred_ex = branch_taken_ex) leaves spec_ghr unchanged.
5. Same-cycle collision: branch_ex updates index 0x40 from 01 to 10 while next_pc maps to 0x40 -> pred_counter = 01 that cycle, 10 the next.
6. flush_req during IDLE with spec_ghr = 0x5A, then a second flush_req 100 cycles into the sweep -> spec_ghr = 0, sweep restarts, init_busy stays high for 256 cycles after the second flush, and all entries read 01.

Source files
------------

// File: rtl/predictor_gshare_bht.sv
// Two-level branch predictor: a table of saturating counters indexed by the fetch PC
// combined with a speculative global history register.
//
// Ports:
//   cpu_clk, cpu_rstn         core clock, asynchronous active-low reset
//   flush_req                 re-initialise the counter table and clear the history
//   init_busy                 high while the table-initialisation sweep runs
//   pred_req, next_pc         fetch consumes a prediction for next_pc this cycle
//   pred_taken, pred_counter  predicted direction and raw counter (forced 0 while busy)
//   pred_ghr                  history used for this prediction, travels with the branch
//   branch_*_ex               EX-stage resolution: valid, taken, predicted, PC, GHR snapshot
//   mispredict_ex             resolved direction differs from the predicted one
module predictor_gshare_bht #(
  parameter int unsigned ENTRY_NUM  = 256,
  parameter int unsigned IDX_WIDTH  = $clog2(ENTRY_NUM),
  parameter int unsigned GHR_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned INDEX_MODE = 1,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  flush_req,
  output logic                  init_busy,
  input  logic                  pred_req,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  pred_taken,
  output logic [CNT_WIDTH-1:0]  pred_counter,
  output logic [GHR_WIDTH-1:0]  pred_ghr,
  input  logic                  branch_ex,
  input  logic                  branch_taken_ex,
  input  logic                  branch_pred_ex,
  input  logic [ADDR_WIDTH-1:0] branch_pc_ex,
  input  logic [GHR_WIDTH-1:0]  branch_ghr_ex,
  output logic                  mispredict_ex
);

  typedef enum logic {StInit, StIdle} state_e;

  localparam logic [CNT_WIDTH-1:0] Wnt     = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] Cmax    = {CNT_WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(ENTRY_NUM - 1);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  init_idx_q, init_idx_d;
  logic [GHR_WIDTH-1:0]  spec_ghr_q, spec_ghr_d;
  logic [CNT_WIDTH-1:0]  cnt_mem [ENTRY_NUM];

  logic [IDX_WIDTH-1:0]  ridx, widx, mem_widx;
  logic [CNT_WIDTH-1:0]  rd_cnt, wr_cur, upd_cnt, mem_wdata;
  logic                  mem_we;
  logic [GHR_WIDTH:0]    ghr_shift, ghr_repair;
  logic                  unused_pc_bits;

  // Mode 0 places the history above the low PC bits; mode 1 folds it into them (gshare).
  function automatic logic [IDX_WIDTH-1:0] calc_idx(input logic [ADDR_WIDTH-1:0] pc,
                                                    input logic [GHR_WIDTH-1:0]  ghr);
    logic [IDX_WIDTH-1:0] pc_bits;
    logic [IDX_WIDTH-1:0] ghr_ext;
    pc_bits = pc[IDX_WIDTH+1:2];
    ghr_ext = IDX_WIDTH'(ghr);
    if (INDEX_MODE == 0) begin
      return (ghr_ext << (IDX_WIDTH - GHR_WIDTH)) |
             (pc_bits & ({IDX_WIDTH{1'b1}} >> GHR_WIDTH));
    end else begin
      return pc_bits ^ ghr_ext;
    end
  endfunction

  assign unused_pc_bits = ^{next_pc[ADDR_WIDTH-1:IDX_WIDTH+2], next_pc[1:0],
                            branch_pc_ex[ADDR_WIDTH-1:IDX_WIDTH+2], branch_pc_ex[1:0]};

  // Read path
  assign ridx          = calc_idx(next_pc, spec_ghr_q);
  assign rd_cnt        = cnt_mem[ridx];
  assign init_busy     = (state_q == StInit);
  assign pred_counter  = init_busy ? '0 : rd_cnt;
  assign pred_taken    = pred_counter[CNT_WIDTH-1];
  assign pred_ghr      = spec_ghr_q;
  assign mispredict_ex = branch_ex && (branch_taken_ex != branch_pred_ex);

  // Update path: same hash on the snapshot so the update lands where the prediction came from
  assign widx   = calc_idx(branch_pc_ex, branch_ghr_ex);
  assign wr_cur = cnt_mem[widx];

  always_comb begin
    upd_cnt = wr_cur;
    if (branch_taken_ex) begin
      if (wr_cur != Cmax) upd_cnt = wr_cur + 1'b1;
    end else begin
      if (wr_cur != '0) upd_cnt = wr_cur - 1'b1;
    end
  end

  // Extra MSB is dropped, which also covers the single-bit history case
  assign ghr_shift  = {spec_ghr_q, pred_taken};
  assign ghr_repair = {branch_ghr_ex, branch_taken_ex};

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    spec_ghr_d = spec_ghr_q;
    mem_we     = 1'b0;
    mem_widx   = init_idx_q;
    mem_wdata  = Wnt;

    case (state_q)
      StInit: begin
        mem_we     = 1'b1;
        // Power-of-two depth: the index wraps back to 0 on the final write
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LastIdx) state_d = StIdle;
      end
      StIdle: begin
        if (branch_ex && !flush_req) begin
          mem_we    = 1'b1;
          mem_widx  = widx;
          mem_wdata = upd_cnt;
        end
        if (mispredict_ex) begin
          spec_ghr_d = ghr_repair[GHR_WIDTH-1:0];
        end else if (pred_req) begin
          spec_ghr_d = ghr_shift[GHR_WIDTH-1:0];
        end
      end
      default: state_d = StInit;
    endcase

    if (flush_req) begin
      state_d    = StInit;
      init_idx_d = '0;
      spec_ghr_d = '0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q    <= StInit;
      init_idx_q <= '0;
      spec_ghr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      spec_ghr_q <= spec_ghr_d;
    end
  end

  // Counter array has no reset; the sweep establishes its contents
  always_ff @(posedge cpu_clk) begin
    if (mem_we) cnt_mem[mem_widx] <= mem_wdata;
  end

endmodule

// File: tb/tb_predictor_gshare_bht.sv
// Self-checking bench for predictor_gshare_bht (default parameters: 256 entries,
// 8-bit history, 2-bit counters, gshare indexing). A behavioural model tracks the
// table, history and sweep countdown; directed steps pin literal values.
module tb_predictor_gshare_bht;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic        flush_req = 1'b0;
  logic        init_busy;
  logic        pred_req = 1'b0;
  logic [31:0] next_pc = '0;
  logic        pred_taken;
  logic [1:0]  pred_counter;
  logic [7:0]  pred_ghr;
  logic        branch_ex = 1'b0;
  logic        branch_taken_ex = 1'b0;
  logic        branch_pred_ex = 1'b0;
  logic [31:0] branch_pc_ex = '0;
  logic [7:0]  branch_ghr_ex = '0;
  logic        mispredict_ex;

  predictor_gshare_bht dut (
    .cpu_clk        (cpu_clk),
    .cpu_rstn       (cpu_rstn),
    .flush_req      (flush_req),
    .init_busy      (init_busy),
    .pred_req       (pred_req),
    .next_pc        (next_pc),
    .pred_taken     (pred_taken),
    .pred_counter   (pred_counter),
    .pred_ghr       (pred_ghr),
    .branch_ex      (branch_ex),
    .branch_taken_ex(branch_taken_ex),
    .branch_pred_ex (branch_pred_ex),
    .branch_pc_ex   (branch_pc_ex),
    .branch_ghr_ex  (branch_ghr_ex),
    .mispredict_ex  (mispredict_ex)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mem [256];
  int m_busy_left = 256;  // sweep cycles still to run; the table is all-WNT once it hits 0
  int m_ghr = 0;

  function automatic int m_idx(input logic [31:0] pc, input int ghr);
    return int'((pc >> 2) % 256) ^ ghr;
  endfunction

  function automatic int m_cnt();
    if (m_busy_left > 0) return 0;
    return m_mem[m_idx(next_pc, m_ghr)];
  endfunction

  function automatic int m_upd(input int v, input bit taken);
    if (taken) return (v == 3) ? 3 : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  always @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      m_busy_left <= 256;
      m_ghr       <= 0;
    end else if (flush_req) begin
      m_busy_left <= 256;
      m_ghr       <= 0;
    end else if (m_busy_left > 0) begin
      m_busy_left <= m_busy_left - 1;
      if (m_busy_left == 1) begin
        for (int i = 0; i < 256; i++) m_mem[i] <= 1;
      end
    end else begin
      if (branch_ex)
        m_mem[m_idx(branch_pc_ex, int'(branch_ghr_ex))] <=
          m_upd(m_mem[m_idx(branch_pc_ex, int'(branch_ghr_ex))], branch_taken_ex);
      if (branch_ex && (branch_taken_ex != branch_pred_ex))
        m_ghr <= (int'(branch_ghr_ex) * 2 + int'(branch_taken_ex)) % 256;
      else if (pred_req)
        m_ghr <= (m_ghr * 2 + ((m_cnt() >= 2) ? 1 : 0)) % 256;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge cpu_clk) begin
    if (cpu_rstn) begin
      check("init_busy", {31'b0, init_busy}, (m_busy_left > 0) ? 1 : 0);
      check("pred_counter", {30'b0, pred_counter}, m_cnt());
      check("pred_taken", {31'b0, pred_taken}, (m_cnt() >= 2) ? 1 : 0);
      check("pred_ghr", {24'b0, pred_ghr}, m_ghr);
      check("mispredict_ex", {31'b0, mispredict_ex},
            (branch_ex && (branch_taken_ex != branch_pred_ex)) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_branch(input bit v, input logic [31:0] pc, input logic [7:0] ghr,
                            input bit taken, input bit pred);
    branch_ex       = v;
    branch_pc_ex    = pc;
    branch_ghr_ex   = ghr;
    branch_taken_ex = taken;
    branch_pred_ex  = pred;
  endtask

  int n;
  int exp_seq [3] = '{2, 3, 3};

  initial begin
    repeat (3) tick();
    cpu_rstn = 1'b1;

    // Reset defaults and sweep length
    check("reset_busy", {31'b0, init_busy}, 1);
    check("reset_ghr", {24'b0, pred_ghr}, 0);
    check("reset_counter", {30'b0, pred_counter}, 0);
    n = 0;
    while (init_busy && n < 1000) begin tick(); n++; end
    check("init_cycles", n, 256);
    next_pc = 32'h1234;
    #1;
    check("idle_counter", {30'b0, pred_counter}, 1);
    check("idle_taken", {31'b0, pred_taken}, 0);

    // Three taken updates at index 0x40 saturate the counter
    next_pc = 32'h100;
    set_branch(1'b1, 32'h100, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_counter", {30'b0, pred_counter}, exp_seq[i]);
    end
    set_branch(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    #1;
    check("sat_taken", {31'b0, pred_taken}, 1);

    // Speculative shifts with predictions 1, 0, 1
    pred_req = 1'b1;
    next_pc  = 32'h100;
    #1;
    check("shift0_ghr", {24'b0, pred_ghr}, 8'h00);
    check("shift0_taken", {31'b0, pred_taken}, 1);
    tick();
    next_pc = 32'h200;
    #1;
    check("shift1_ghr", {24'b0, pred_ghr}, 8'h01);
    check("shift1_taken", {31'b0, pred_taken}, 0);
    tick();
    next_pc = 32'h108;
    #1;
    check("shift2_ghr", {24'b0, pred_ghr}, 8'h02);
    check("shift2_taken", {31'b0, pred_taken}, 1);
    tick();
    pred_req = 1'b0;
    check("shift_final_ghr", {24'b0, pred_ghr}, 8'h05);

    // Mispredict repair wins over a same-cycle shift
    pred_req = 1'b1;
    set_branch(1'b1, 32'h400, 8'h81, 1'b1, 1'b0);
    #1;
    check("mispredict_flag", {31'b0, mispredict_ex}, 1);
    tick();
    pred_req = 1'b0;
    set_branch(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    check("repair_ghr", {24'b0, pred_ghr}, 8'h03);
    set_branch(1'b1, 32'h400, 8'h81, 1'b0, 1'b0);
    #1;
    check("correct_flag", {31'b0, mispredict_ex}, 0);
    tick();
    set_branch(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    check("correct_ghr", {24'b0, pred_ghr}, 8'h03);

    // Flush, then re-flush mid-sweep
    set_branch(1'b1, 32'h400, 8'h2D, 1'b0, 1'b1);
    tick();
    set_branch(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    check("pre_flush_ghr", {24'b0, pred_ghr}, 8'h5A);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush_ghr", {24'b0, pred_ghr}, 0);
    check("flush_busy", {31'b0, init_busy}, 1);
    repeat (99) tick();
    check("mid_sweep_busy", {31'b0, init_busy}, 1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    while (init_busy && n < 1000) begin tick(); n++; end
    check("reflush_cycles", n, 256);
    for (int i = 0; i < 256; i++) begin
      next_pc = 32'(i) * 4;
      #1;
      check("swept_entry", {30'b0, pred_counter}, 1);
    end

    // Same-cycle read/update collision at index 0x40
    next_pc = 32'h100;
    set_branch(1'b1, 32'h100, 8'h00, 1'b1, 1'b1);
    #1;
    check("collide_before", {30'b0, pred_counter}, 1);
    tick();
    set_branch(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    check("collide_after", {30'b0, pred_counter}, 2);

    // Randomised traffic, with occasional flushes and asynchronous resets
    for (int c = 0; c < 4000; c++) begin
      flush_req       = ($urandom_range(0, 299) == 0);
      pred_req        = $urandom_range(0, 1) == 1;
      next_pc         = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      branch_ex       = $urandom_range(0, 2) != 0;
      branch_pc_ex    = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      branch_ghr_ex   = ($urandom_range(0, 1) == 1) ? 8'(m_ghr) : 8'($urandom_range(0, 3));
      branch_taken_ex = $urandom_range(0, 1) == 1;
      // History repair during the sweep is left unexercised
      if (m_busy_left > 0 || $urandom_range(0, 3) != 0) branch_pred_ex = branch_taken_ex;
      else branch_pred_ex = !branch_taken_ex;
      if (c == 1500 || $urandom_range(0, 1999) == 0) begin
        cpu_rstn = 1'b0;
        #2;
        cpu_rstn = 1'b1;
      end
      tick();
    end

    flush_req = 1'b0;
    pred_req  = 1'b0;
    set_branch(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
